aud_voice_mixer: RTL and testbench
==================================

// Module: aud_voice_mixer
// PURPOSE
//   Downstream stage of the AudioVoice AXI-Stream master (tdata 32b, tid 3b = voice index).
//   Keeps the latest sample per voice and snapshots all voices on each audio-rate sample_tick.
//   Sums the enabled voices serially, applies a right-shift gain and saturates the result.
//   Presents one mixed sample per tick on an AXI-Stream master for the codec/PWM output stage.
// PARAMETERS
//   NUM_VOICES  8   voices addressed by tid; must be a power of 2 and <= 8.
//   SAMPLE_W    16  signed sample width, taken from s_axis_tdata[SAMPLE_W-1:0]; upper bits ignored.
//   OUT_W       16  signed output width; OUT_W <= SAMPLE_W+3.
//   GAIN_SHIFT  3   arithmetic right shift applied to the accumulator before saturation.
// PORTS
//   axi_clk          in   1         single clock for all logic.
//   reset            in   1         synchronous, active-high reset.
//   sample_tick      in   1         1-cycle pulse at the audio rate, already synchronous to axi_clk.
//   voice_mask       in   NUM_VOICES  bit v=1 includes voice v in the mix; sampled at the tick.
//   s_axis_tdata     in   32        voice sample; signed value in [SAMPLE_W-1:0].
//   s_axis_tid       in   3         voice index; values >= NUM_VOICES are accepted and discarded.
//   s_axis_tvalid    in   1         input beat valid.
//   s_axis_tready    out  1         0 during reset, otherwise 1 (always accepts).
//   m_axis_tdata     out  OUT_W     mixed, saturated sample.
//   m_axis_tvalid    out  1         mixed sample available.
//   m_axis_tready    in   1         downstream accept.
//   overrun          out  1         sticky: a tick arrived while the mixer was busy.
//   clear_overrun    in   1         1-cycle pulse that clears overrun.
// BEHAVIOUR
//   Reset: every voice register and the snapshot are 0, accumulator is 0, FSM is IDLE.
//     s_axis_tready=0, m_axis_tdata=0, m_axis_tvalid=0, overrun=0.
//     Reset asserted mid-SUM or mid-OUT aborts the operation; a pending output is discarded.
//   Input: a beat with s_axis_tvalid=1 and a valid tid writes voice_reg[tid].
//     A voice keeps its last value until it is rewritten; missing beats hold the old sample.
//   FSM states: IDLE, SUM, OUT.
//   IDLE -> SUM on sample_tick:
//     snapshot[v] <= voice_reg[v], or masked to 0 when voice_mask[v]=0.
//     Clear the accumulator; idx <= 0.
//     If an input beat lands in the same cycle as the tick, its new value goes into the snapshot (write-through).
//   SUM: each cycle acc <= acc + sign_ext(snapshot[idx]); idx++.
//     acc is SAMPLE_W+3 bits, so it cannot overflow.
//     After idx = NUM_VOICES-1, go to OUT.
//   OUT entry: m_axis_tdata <= sat(acc >>> GAIN_SHIFT), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//     m_axis_tvalid <= 1.
//   Latency: tick sampled at edge E0; tvalid is high after edge E(NUM_VOICES+1) (E9 for the default).
//   OUT: tdata/tvalid hold stable until m_axis_tvalid and m_axis_tready are both 1; then go to IDLE with tvalid=0.
//     A new tick in the accept cycle is treated as busy (overrun); it is not started.
//   sample_tick while in SUM or OUT: the tick is dropped and overrun <= 1.
//     Voice register writes continue regardless of FSM state.
//   overrun clears only on reset or clear_overrun. If clear_overrun and a new overrun occur in the same cycle, set wins.
//   The voice_mask is used only at the snapshot; changes during SUM/OUT do not affect the current mix.
// TESTING
//   1. Reset: hold reset 3 cycles -> s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, overrun=0.
//   2. Write voices 0..7 = 100..800, mask=8'hFF, GAIN_SHIFT=3, tick.
//      Expect tvalid 9 cycles later with tdata=450 (3600>>>3); it holds until tready=1.
//   3. Saturation: all 8 voices = 16'h7FFF, mask=FF, GAIN_SHIFT=0 -> tdata=16'h7FFF.
//      All voices = 16'h8000 -> tdata=16'h8000.
//   4. Mask and tid: write tid=1:-200, tid=2:50, mask=8'h02, tick -> tdata=-25.
//      A beat with tid >= NUM_VOICES (NUM_VOICES=4) changes nothing.
//   5. Busy: hold tready=0 after a mix and issue a 2nd tick -> overrun=1 and the first sample is unchanged.
//      clear_overrun -> overrun=0.
//   6. Same-cycle tick and tid=0 beat of 800 (others 0, shift 3) -> tdata=100.
//      Reset asserted during SUM -> tvalid never rises.

Source files
------------

// File: rtl/aud_voice_mixer.sv
// Per-voice sample store, tick-driven snapshot, serial sum, shift-gain and saturation to one AXI-Stream sample.
// Tick at edge E0 gives m_axis_tvalid after edge E(NUM_VOICES+1); output holds until accepted, input always ready.
module aud_voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W   = 16,
  parameter int OUT_W      = 16,
  parameter int GAIN_SHIFT = 3
) (
  input  logic                  axi_clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [NUM_VOICES-1:0] voice_mask,
  input  logic [31:0]           s_axis_tdata,
  input  logic [2:0]            s_axis_tid,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [OUT_W-1:0]      m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overrun,
  input  logic                  clear_overrun
);

  localparam int ACC_W = SAMPLE_W + 3;
  localparam int IDX_W = $clog2(NUM_VOICES) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

  state_t                     state_q;
  logic signed [SAMPLE_W-1:0] voice_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] voice_d [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] snap_q  [NUM_VOICES];
  logic [IDX_W-1:0]           idx_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    shifted;
  logic [OUT_W-1:0]           sat_d;
  logic [OUT_W-1:0]           tdata_q;
  logic                       tvalid_q;
  logic                       overrun_q;
  logic                       overrun_d;
  logic signed [SAMPLE_W-1:0] cur_sample;

  // Next voice values; the tick snapshot reads these so a same-cycle beat is written through.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_d[v] = voice_q[v];
      if (s_axis_tvalid && (s_axis_tid == 3'(v)))
        voice_d[v] = s_axis_tdata[SAMPLE_W-1:0];
    end
  end

  always_comb begin
    cur_sample = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (idx_q == IDX_W'(v))
        cur_sample = snap_q[v];
    end
  end

  assign acc_d   = acc_q + signed'({{3{cur_sample[SAMPLE_W-1]}}, cur_sample});
  assign shifted = acc_q >>> GAIN_SHIFT;

  always_comb begin
    sat_d = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX)
      sat_d = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN)
      sat_d = SAT_MIN[OUT_W-1:0];
  end

  // A busy tick sets overrun even when clear_overrun pulses in the same cycle.
  assign overrun_d = (overrun_q & ~clear_overrun) | (sample_tick & (state_q != IDLE));

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_q[v] <= '0;
        snap_q[v]  <= '0;
      end
    end else begin
      overrun_q <= overrun_d;
      for (int v = 0; v < NUM_VOICES; v++)
        voice_q[v] <= voice_d[v];
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            for (int v = 0; v < NUM_VOICES; v++)
              snap_q[v] <= voice_mask[v] ? voice_d[v] : '0;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= SUM;
          end
        end
        SUM: begin
          // One extra cycle past the last voice lets the final sum settle before it is scaled.
          if (idx_q == IDX_W'(NUM_VOICES)) begin
            tdata_q  <= sat_d;
            tvalid_q <= 1'b1;
            state_q  <= OUT;
          end else begin
            acc_q <= acc_d;
            idx_q <= idx_q + 1'b1;
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            tvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = ~reset;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_aud_voice_mixer.sv
// Directed bench for aud_voice_mixer: three instances (8 voices/shift 3, 8 voices/shift 0, 4 voices/shift 3) share stimulus.
module tb_aud_voice_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [7:0]  voice_mask = 8'h00;
  logic [31:0] s_axis_tdata = 32'h0;
  logic [2:0]  s_axis_tid = 3'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        clear_overrun = 1'b0;

  logic        rdy8, rdyg0, rdy4;
  logic [15:0] td8, tdg0, td4;
  logic        tv8, tvg0, tv4;
  logic        ov8, ovg0, ov4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aud_voice_mixer #(.NUM_VOICES(8), .SAMPLE_W(16), .OUT_W(16), .GAIN_SHIFT(3)) dut (
    .axi_clk(clk), .reset(reset), .sample_tick(sample_tick), .voice_mask(voice_mask),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(rdy8), .m_axis_tdata(td8), .m_axis_tvalid(tv8), .m_axis_tready(m_axis_tready),
    .overrun(ov8), .clear_overrun(clear_overrun));

  aud_voice_mixer #(.NUM_VOICES(8), .SAMPLE_W(16), .OUT_W(16), .GAIN_SHIFT(0)) dut_g0 (
    .axi_clk(clk), .reset(reset), .sample_tick(sample_tick), .voice_mask(voice_mask),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(rdyg0), .m_axis_tdata(tdg0), .m_axis_tvalid(tvg0), .m_axis_tready(m_axis_tready),
    .overrun(ovg0), .clear_overrun(clear_overrun));

  aud_voice_mixer #(.NUM_VOICES(4), .SAMPLE_W(16), .OUT_W(16), .GAIN_SHIFT(3)) dut4 (
    .axi_clk(clk), .reset(reset), .sample_tick(sample_tick), .voice_mask(voice_mask[3:0]),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(rdy4), .m_axis_tdata(td4), .m_axis_tvalid(tv4), .m_axis_tready(m_axis_tready),
    .overrun(ov4), .clear_overrun(clear_overrun));

  typedef struct {
    logic [7:0][15:0] v;
    logic [7:0]       mask;
    int               e8;
    int               eg0;
    int               e4;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_voice(input int tid, input logic [15:0] val);
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 3'(tid);
    s_axis_tdata  = {16'hDEAD, val};
    step();
    s_axis_tvalid = 1'b0;
  endtask

  // Pulses the tick (with any beat the caller has already placed on the input) and waits for the result.
  task automatic do_tick(input logic [7:0] mask, input string tag);
    int cnt;
    voice_mask  = mask;
    sample_tick = 1'b1;
    step();
    sample_tick   = 1'b0;
    s_axis_tvalid = 1'b0;
    cnt = 0;
    while (tv8 !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, " latency"}, cnt, 9);
  endtask

  task automatic accept(input string tag);
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    check({tag, " tvalid after accept"}, {31'b0, tv8}, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[0].v[i] = 16'(100 * (i + 1));
      vecs[1].v[i] = 16'(100 * (i + 1));
      vecs[2].v[i] = 16'h7FFF;
      vecs[3].v[i] = 16'h8000;
      vecs[4].v[i] = (i >= 4) ? 16'd1000 : 16'd0;
    end
    vecs[4].v[1] = 16'hFF38;  // -200
    vecs[4].v[2] = 16'd50;
    vecs[5].v = vecs[4].v;
    vecs[6].v = vecs[4].v;
    vecs[0].mask = 8'hFF; vecs[0].e8 = 450;    vecs[0].eg0 = 3600;   vecs[0].e4 = 125;
    vecs[1].mask = 8'h55; vecs[1].e8 = 200;    vecs[1].eg0 = 1600;   vecs[1].e4 = 50;
    vecs[2].mask = 8'hFF; vecs[2].e8 = 32767;  vecs[2].eg0 = 32767;  vecs[2].e4 = 16383;
    vecs[3].mask = 8'hFF; vecs[3].e8 = -32768; vecs[3].eg0 = -32768; vecs[3].e4 = -16384;
    vecs[4].mask = 8'h02; vecs[4].e8 = -25;    vecs[4].eg0 = -200;   vecs[4].e4 = -25;
    vecs[5].mask = 8'h0F; vecs[5].e8 = -19;    vecs[5].eg0 = -150;   vecs[5].e4 = -19;
    vecs[6].mask = 8'hFF; vecs[6].e8 = 481;    vecs[6].eg0 = 3850;   vecs[6].e4 = -19;

    // Reset held three cycles
    reset = 1'b1;
    repeat (3) step();
    check("reset tready", {31'b0, rdy8}, 0);
    check("reset tvalid", {31'b0, tv8}, 0);
    check("reset tdata", $signed(td8), 0);
    check("reset overrun", {31'b0, ov8}, 0);
    reset = 1'b0;
    step();
    check("tready after reset", {31'b0, rdy8}, 1);

    // Table-driven mixes
    for (int k = 0; k < 7; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      for (int i = 0; i < 8; i++)
        write_voice(i, vecs[k].v[i]);
      do_tick(vecs[k].mask, tag);
      check({tag, " tdata n8 g3"}, $signed(td8), vecs[k].e8);
      check({tag, " tdata n8 g0"}, $signed(tdg0), vecs[k].eg0);
      check({tag, " tdata n4 g3"}, $signed(td4), vecs[k].e4);
      if (k == 0) begin
        repeat (3) step();
        check("hold tvalid", {31'b0, tv8}, 1);
        check("hold tdata", $signed(td8), 450);
      end
      accept(tag);
    end

    // Busy tick while output is held: overrun set, sample untouched
    do_tick(8'hFF, "busy");
    check("busy first tdata", $signed(td8), 481);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("busy overrun set", {31'b0, ov8}, 1);
    check("busy tdata kept", $signed(td8), 481);
    check("busy tvalid kept", {31'b0, tv8}, 1);
    sample_tick   = 1'b1;
    clear_overrun = 1'b1;
    step();
    sample_tick   = 1'b0;
    clear_overrun = 1'b0;
    check("set beats clear", {31'b0, ov8}, 1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("overrun cleared", {31'b0, ov8}, 0);
    step();
    check("overrun stays clear", {31'b0, ov8}, 0);

    // Tick in the accept cycle is busy and does not start a mix
    m_axis_tready = 1'b1;
    sample_tick   = 1'b1;
    step();
    m_axis_tready = 1'b0;
    sample_tick   = 1'b0;
    check("accept-cycle tick overrun", {31'b0, ov8}, 1);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        step();
        if (tv8 === 1'b1) seen++;
      end
      check("accept-cycle tick not started", seen, 0);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;

    // Same-cycle tick and tid=0 beat writes through to the snapshot
    for (int i = 0; i < 8; i++)
      write_voice(i, 16'd0);
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 3'd0;
    s_axis_tdata  = {16'hBEEF, 16'd800};
    do_tick(8'hFF, "writethru");
    check("writethru tdata n8", $signed(td8), 100);
    check("writethru tdata g0", $signed(tdg0), 800);
    check("writethru overrun", {31'b0, ov8}, 0);
    accept("writethru");

    // Reset during SUM aborts the mix
    voice_mask  = 8'hFF;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("mid-sum reset tready", {31'b0, rdy8}, 0);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        step();
        if (tv8 === 1'b1) seen++;
      end
      check("mid-sum reset no tvalid", seen, 0);
    end
    do_tick(8'hFF, "post-reset");
    check("post-reset voices cleared", $signed(td8), 0);
    accept("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
